// File: rtl/sram1rw_req_ctrl_pkg.sv
// Shared types and helpers for the SRAM1RW request controller.
// Holds the FSM state encoding, default geometry and the byte-merge helper.
package sram_ctrl_pkg;

  localparam int DEF_ADDR_WIDTH = 7;
  localparam int DEF_DATA_WIDTH = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } state_e;

  // Select the new byte where the write enable is set, otherwise keep the old byte.
  function automatic logic [7:0] merge_byte(input logic en, input logic [7:0] new_byte,
                                            input logic [7:0] old_byte);
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/sram1rw_req_ctrl_if.sv
// User-side request and read-response channels of the SRAM1RW controller.
// The master drives requests and accepts responses; the controller is the slave.
interface sram1rw_req_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [MASK_WIDTH-1:0] req_wmask;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );

endinterface

// File: rtl/sram1rw_req_ctrl_resp_fifo.sv
// Small synchronous FIFO holding read responses the consumer has not yet taken.
// The head word is visible combinationally so it can be presented without an extra cycle.
module sram_resp_fifo #(
  parameter  int DEPTH      = 2,
  parameter  int DATA_WIDTH = 64,
  localparam int CNT_W      = $clog2(DEPTH + 1),
  localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enq,
  input  logic [DATA_WIDTH-1:0] enq_data,
  input  logic                  deq,
  output logic [DATA_WIDTH-1:0] deq_data,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  do_enq;
  logic                  do_deq;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign deq_data = mem_reg[rd_ptr_reg];

  // A full FIFO may still accept a word when the head leaves in the same cycle.
  assign do_enq = enq && (!full || deq);
  assign do_deq = deq && !empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_enq) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (do_deq) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + CNT_W'(do_enq) - CNT_W'(do_deq);
    end
  end

  always_ff @(posedge clock) begin
    if (do_enq) begin
      mem_reg[wr_ptr_reg] <= enq_data;
    end
  end

endmodule

// File: rtl/sram1rw_req_ctrl.sv
// Initiator-side controller for a single-port SRAM1RW macro: drives the macro pins,
// absorbs its one-cycle read latency and emulates byte-masked writes via read-modify-write.
module sram1rw_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  sram1rw_req_ctrl_if.slave     bus,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic                  sram_oeb,
  output logic [DATA_WIDTH-1:0] sram_i,
  input  logic [DATA_WIDTH-1:0] sram_o
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int CNT_W      = $clog2(RESP_DEPTH + 1);

  state_e                state_reg, state_next;
  logic                  rd_pending_reg, rd_pending_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [MASK_WIDTH-1:0] mask_reg;
  logic                  latch_en;
  logic [DATA_WIDTH-1:0] merged_data;

  logic                  req_ready;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  fifo_enq;
  logic                  fifo_deq;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [CNT_W:0]        credit_sum;
  logic                  read_credit;
  logic                  full_mask;

  generate
    for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_merge
      assign merged_data[gi*8 +: 8] =
        merge_byte(mask_reg[gi], wdata_reg[gi*8 +: 8], sram_o[gi*8 +: 8]);
    end
  endgenerate

  // A read may only launch if its response has a guaranteed FIFO slot.
  assign credit_sum  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pending_reg};
  assign read_credit = (credit_sum < (CNT_W + 1)'(RESP_DEPTH));
  assign full_mask   = &bus.req_wmask;

  always_comb begin
    state_next      = state_reg;
    rd_pending_next = 1'b0;
    latch_en        = 1'b0;
    req_ready       = 1'b0;
    sram_csb        = 1'b1;
    sram_web        = 1'b1;
    sram_oeb        = 1'b1;
    sram_a          = '0;
    sram_i          = '0;
    if (!reset) begin
      case (state_reg)
        IDLE: begin
          req_ready = bus.req_write ? 1'b1 : read_credit;
          if (bus.req_valid && req_ready) begin
            sram_csb = 1'b0;
            sram_a   = bus.req_addr;
            if (!bus.req_write) begin
              sram_oeb        = 1'b0;
              rd_pending_next = 1'b1;
            end else if (full_mask) begin
              sram_web = 1'b0;
              sram_i   = bus.req_wdata;
            end else begin
              // Fetch the old word; its response is consumed by MERGE, not the user.
              sram_oeb   = 1'b0;
              latch_en   = 1'b1;
              state_next = MERGE;
            end
          end
        end
        MERGE: begin
          sram_csb   = 1'b0;
          sram_web   = 1'b0;
          sram_a     = addr_reg;
          sram_i     = merged_data;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    resp_valid = 1'b0;
    resp_rdata = fifo_head;
    fifo_enq   = 1'b0;
    fifo_deq   = 1'b0;
    if (!reset) begin
      if (fifo_empty) begin
        if (rd_pending_reg) begin
          resp_valid = 1'b1;
          resp_rdata = sram_o;
          fifo_enq   = !bus.resp_ready;
        end
      end else begin
        resp_valid = 1'b1;
        fifo_enq   = rd_pending_reg;
        fifo_deq   = bus.resp_ready;
      end
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_rdata = resp_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      rd_pending_reg <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      mask_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      rd_pending_reg <= rd_pending_next;
      if (latch_en) begin
        addr_reg  <= bus.req_addr;
        wdata_reg <= bus.req_wdata;
        mask_reg  <= bus.req_wmask;
      end
    end
  end

  sram_resp_fifo #(
    .DEPTH      (RESP_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_resp_fifo (
    .clock    (clock),
    .reset    (reset),
    .enq      (fifo_enq),
    .enq_data (sram_o),
    .deq      (fifo_deq),
    .deq_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // Full flag is implied by the credit check; kept for observability only.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_sram1rw_req_ctrl.sv
// Directed bench for sram1rw_req_ctrl with a behavioural SRAM1RW macro model.
// Inputs change 1 time unit after posedge; outputs are compared 1 unit later.
module tb_sram1rw_req_ctrl;

  logic        clock;
  logic        reset;
  logic [6:0]  sram_a;
  logic        sram_csb;
  logic        sram_web;
  logic        sram_oeb;
  logic [63:0] sram_i;
  logic [63:0] sram_o;

  int n_cmp = 0;
  int n_err = 0;
  int wr20_cnt = 0;
  int wr20_before;
  logic [63:0] rd_val [1:4];

  sram1rw_req_ctrl_if #(.ADDR_WIDTH(7), .DATA_WIDTH(64)) bus ();

  sram1rw_req_ctrl #(.ADDR_WIDTH(7), .DATA_WIDTH(64), .RESP_DEPTH(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .sram_a   (sram_a),
    .sram_csb (sram_csb),
    .sram_web (sram_web),
    .sram_oeb (sram_oeb),
    .sram_i   (sram_i),
    .sram_o   (sram_o)
  );

  // Macro model: write or read at the edge; read data held on O afterwards.
  logic [63:0] mem [0:127];
  logic [63:0] o_reg;
  assign sram_o = o_reg;
  always @(posedge clock) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_a] <= sram_i;
      else if (!sram_oeb) o_reg <= mem[sram_a];
    end
  end

  always @(posedge clock) begin
    if (!sram_csb && !sram_web && sram_a == 7'h20) wr20_cnt++;
    if (!reset && bus.req_valid && bus.req_ready)
      $display("req  w=%0d addr=%h wdata=%h mask=%h", bus.req_write, bus.req_addr,
               bus.req_wdata, bus.req_wmask);
    if (!reset && bus.resp_valid && bus.resp_ready)
      $display("resp rdata=%h", bus.resp_rdata);
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [6:0] a,
                       input logic [63:0] d, input logic [7:0] m);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wmask = m;
    #1;
  endtask

  task automatic drive_idle;
    drive(1'b0, 1'b0, 7'h00, 64'h0, 8'h00);
  endtask

  task automatic do_write(input logic [6:0] a, input logic [63:0] d);
    drive(1'b1, 1'b1, a, d, 8'hFF);
    cyc();
    drive_idle();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b1, 1'b1, 7'h05, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    cyc();
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); end
    n_cmp++; if ({sram_csb, sram_web, sram_oeb} !== 3'b111) begin n_err++; $display("FAIL rst_pins: got %b want 111", {sram_csb, sram_web, sram_oeb}); end
    cyc();
    reset = 1'b0;
    drive_idle();
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL idle_ready: got %b want 1", bus.req_ready); end
    n_cmp++; if ({sram_csb, sram_web, sram_oeb} !== 3'b111) begin n_err++; $display("FAIL idle_pins: got %b want 111", {sram_csb, sram_web, sram_oeb}); end
    n_cmp++; if (sram_a !== 7'h00 || sram_i !== 64'h0) begin n_err++; $display("FAIL idle_ai: got a=%h i=%h want 0/0", sram_a, sram_i); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL idle_resp_valid: got %b want 0", bus.resp_valid); end
  endtask

  task automatic test_full_write_read;
    drive(1'b1, 1'b1, 7'h05, 64'hDEADBEEF_01234567, 8'hFF);
    n_cmp++; if ({sram_csb, sram_web, sram_oeb} !== 3'b001) begin n_err++; $display("FAIL fw_pins: got %b want 001", {sram_csb, sram_web, sram_oeb}); end
    n_cmp++; if (sram_a !== 7'h05 || sram_i !== 64'hDEADBEEF_01234567) begin n_err++; $display("FAIL fw_ai: got a=%h i=%h want 05/deadbeef01234567", sram_a, sram_i); end
    cyc();
    drive(1'b1, 1'b0, 7'h05, 64'h0, 8'h00);
    n_cmp++; if ({sram_csb, sram_web, sram_oeb, sram_a} !== {3'b010, 7'h05}) begin n_err++; $display("FAIL rd_pins: got %b a=%h want 010 a=05", {sram_csb, sram_web, sram_oeb}, sram_a); end
    cyc();
    drive_idle();
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 64'hDEADBEEF_01234567) begin n_err++; $display("FAIL raw_resp: got v=%b d=%h want 1/deadbeef01234567", bus.resp_valid, bus.resp_rdata); end
    n_cmp++; if (sram_csb !== 1'b1 || sram_web !== 1'b1) begin n_err++; $display("FAIL fw_one_cycle: got csb=%b web=%b want 1/1", sram_csb, sram_web); end
    cyc();
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL raw_resp_end: got %b want 0", bus.resp_valid); end
  endtask

  task automatic test_partial_write;
    do_write(7'h10, 64'h1111_1111_1111_1111);
    drive(1'b1, 1'b1, 7'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    n_cmp++; if (bus.req_ready !== 1'b1 || {sram_csb, sram_web, sram_oeb} !== 3'b010) begin n_err++; $display("FAIL pw_read: got rdy=%b pins=%b want 1/010", bus.req_ready, {sram_csb, sram_web, sram_oeb}); end
    cyc();
    drive(1'b1, 1'b0, 7'h10, 64'h0, 8'h00);
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL pw_merge_ready: got %b want 0", bus.req_ready); end
    n_cmp++; if ({sram_csb, sram_web, sram_oeb, sram_a} !== {3'b001, 7'h10}) begin n_err++; $display("FAIL pw_merge_pins: got %b a=%h want 001 a=10", {sram_csb, sram_web, sram_oeb}, sram_a); end
    n_cmp++; if (sram_i !== 64'h1111_1111_AAAA_AAAA) begin n_err++; $display("FAIL pw_merge_data: got %h want 11111111aaaaaaaa", sram_i); end
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL pw_no_resp: got %b want 0", bus.resp_valid); end
    cyc();
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL pw_after_ready: got %b want 1", bus.req_ready); end
    cyc();
    drive_idle();
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 64'h1111_1111_AAAA_AAAA) begin n_err++; $display("FAIL pw_readback: got v=%b d=%h want 1/11111111aaaaaaaa", bus.resp_valid, bus.resp_rdata); end
    cyc();
  endtask

  task automatic test_back_to_back;
    bus.resp_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 1'b0, 7'(k), 64'h0, 8'h00);
      n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready%0d: got %b want 1", k, bus.req_ready); end
      if (k >= 2) begin
        n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== rd_val[k-1]) begin n_err++; $display("FAIL b2b_resp%0d: got v=%b d=%h want 1/%h", k - 1, bus.resp_valid, bus.resp_rdata, rd_val[k-1]); end
      end
      cyc();
    end
    drive_idle();
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== rd_val[4]) begin n_err++; $display("FAIL b2b_resp4: got v=%b d=%h want 1/%h", bus.resp_valid, bus.resp_rdata, rd_val[4]); end
    cyc();
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end: got %b want 0", bus.resp_valid); end
  endtask

  task automatic test_backpressure;
    bus.resp_ready = 1'b0;
    drive(1'b1, 1'b0, 7'h01, 64'h0, 8'h00);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1: got %b want 1", bus.req_ready); end
    cyc();
    drive(1'b1, 1'b0, 7'h02, 64'h0, 8'h00);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready2: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== rd_val[1]) begin n_err++; $display("FAIL bp_bypass1: got v=%b d=%h want 1/%h", bus.resp_valid, bus.resp_rdata, rd_val[1]); end
    cyc();
    drive(1'b1, 1'b0, 7'h03, 64'h0, 8'h00);
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall3: got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.resp_rdata !== rd_val[1]) begin n_err++; $display("FAIL bp_head1: got %h want %h", bus.resp_rdata, rd_val[1]); end
    cyc();
    bus.resp_ready = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL bp_full: got %b want 0", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== rd_val[1]) begin n_err++; $display("FAIL bp_drain1: got v=%b d=%h want 1/%h", bus.resp_valid, bus.resp_rdata, rd_val[1]); end
    cyc();
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready3: got %b want 1", bus.req_ready); end
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== rd_val[2]) begin n_err++; $display("FAIL bp_drain2: got v=%b d=%h want 1/%h", bus.resp_valid, bus.resp_rdata, rd_val[2]); end
    cyc();
    drive(1'b1, 1'b0, 7'h04, 64'h0, 8'h00);
    n_cmp++; if (bus.req_ready !== 1'b1 || bus.resp_rdata !== rd_val[3]) begin n_err++; $display("FAIL bp_resp3: got rdy=%b d=%h want 1/%h", bus.req_ready, bus.resp_rdata, rd_val[3]); end
    cyc();
    drive_idle();
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== rd_val[4]) begin n_err++; $display("FAIL bp_resp4: got v=%b d=%h want 1/%h", bus.resp_valid, bus.resp_rdata, rd_val[4]); end
    cyc();
    n_cmp++; if (bus.resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_end: got %b want 0", bus.resp_valid); end
  endtask

  task automatic test_reset_in_merge;
    wr20_before = wr20_cnt;
    drive(1'b1, 1'b1, 7'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    cyc();
    reset = 1'b1;
    drive_idle();
    n_cmp++; if (sram_web !== 1'b1 || sram_csb !== 1'b1) begin n_err++; $display("FAIL rm_pins: got csb=%b web=%b want 1/1", sram_csb, sram_web); end
    n_cmp++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin n_err++; $display("FAIL rm_outputs: got v=%b rdy=%b want 0/0", bus.resp_valid, bus.req_ready); end
    cyc();
    reset = 1'b0;
    drive(1'b1, 1'b0, 7'h20, 64'h0, 8'h00);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rm_idle_ready: got %b want 1", bus.req_ready); end
    cyc();
    drive_idle();
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 64'h0) begin n_err++; $display("FAIL rm_readback: got v=%b d=%h want 1/0", bus.resp_valid, bus.resp_rdata); end
    n_cmp++; if (wr20_cnt !== wr20_before) begin n_err++; $display("FAIL rm_no_write: got %0d writes want 0", wr20_cnt - wr20_before); end
    cyc();
  endtask

  task automatic test_mask_edges;
    drive(1'b1, 1'b1, 7'h30, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    n_cmp++; if (sram_web !== 1'b1 || sram_oeb !== 1'b0) begin n_err++; $display("FAIL m00_read: got web=%b oeb=%b want 1/0", sram_web, sram_oeb); end
    cyc();
    drive_idle();
    n_cmp++; if (sram_web !== 1'b0 || sram_i !== 64'h5555_5555_5555_5555) begin n_err++; $display("FAIL m00_merge: got web=%b i=%h want 0/5555555555555555", sram_web, sram_i); end
    cyc();
    drive(1'b1, 1'b0, 7'h30, 64'h0, 8'h00);
    cyc();
    drive(1'b1, 1'b1, 7'h31, 64'h0123_4567_89AB_CDEF, 8'hFF);
    n_cmp++; if (bus.resp_rdata !== 64'h5555_5555_5555_5555) begin n_err++; $display("FAIL m00_readback: got %h want 5555555555555555", bus.resp_rdata); end
    n_cmp++; if (sram_web !== 1'b0 || sram_i !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL mff_single: got web=%b i=%h want 0/0123456789abcdef", sram_web, sram_i); end
    cyc();
    drive(1'b1, 1'b0, 7'h31, 64'h0, 8'h00);
    n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL mff_no_merge: got %b want 1", bus.req_ready); end
    cyc();
    drive_idle();
    n_cmp++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 64'h0123_4567_89AB_CDEF) begin n_err++; $display("FAIL mff_readback: got v=%b d=%h want 1/0123456789abcdef", bus.resp_valid, bus.resp_rdata); end
    cyc();
  endtask

  initial begin
    rd_val[1] = 64'hA5A5_0000_1111_0001;
    rd_val[2] = 64'hA5A5_0000_2222_0002;
    rd_val[3] = 64'hA5A5_0000_3333_0003;
    rd_val[4] = 64'hA5A5_0000_4444_0004;
    bus.resp_ready = 1'b1;
    test_reset();
    for (int k = 1; k <= 4; k++) do_write(7'(k), rd_val[k]);
    do_write(7'h20, 64'h0);
    do_write(7'h30, 64'h5555_5555_5555_5555);
    test_full_write_read();
    test_partial_write();
    test_back_to_back();
    test_backpressure();
    test_reset_in_merge();
    test_mask_edges();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram1rw_req_ctrl.md
Name: sram1rw_req_ctrl

Overview:
Initiator-side controller for the single-port SRAM1RW macros. The user side is a valid/ready request channel and a valid/ready read-response channel. The controller drives the macro pins (A, CSB, WEB, OEB, I) and absorbs the macro's one-cycle read latency. It adds byte-masked writes by doing read-modify-write, since the macro has no write mask. It sits between core-side logic and one SRAM1RW<D>x<W> instance; the macro's CE is tied to the same clock outside this block.

Parameters:
ADDR_WIDTH, 7, macro address width (depth 2^ADDR_WIDTH)
DATA_WIDTH, 64, macro word width; must be a multiple of 8
MASK_WIDTH, DATA_WIDTH/8, byte-enable width (derived, not overridden)
RESP_DEPTH, 2, response FIFO entries; minimum 2

Ports:
clock  in  1  sole clock; also drives macro CE externally
reset  in  1  synchronous, active-high
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid&&ready at posedge
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  word address
req_wdata  in  DATA_WIDTH  write data
req_wmask  in  MASK_WIDTH  byte enables; ignored for reads
resp_valid  out  1  read data valid
resp_ready  in  1  consumer ready
resp_rdata  out  DATA_WIDTH  read data
sram_a  out  ADDR_WIDTH  to macro A
sram_csb  out  1  to macro CSB (active-low)
sram_web  out  1  to macro WEB (active-low)
sram_oeb  out  1  to macro OEB (active-low)
sram_i  out  DATA_WIDTH  to macro I
sram_o  in  DATA_WIDTH  from macro O; valid the cycle after a read edge

Behaviour:
- Macro pins are combinational from the current state and the request. The macro samples them at the same posedge that completes the handshake.
- Idle pins: csb=1, web=1, oeb=1, a=0, i=0.
- While reset=1: req_ready=0, resp_valid=0, csb/web/oeb=1.
- At the reset edge: FSM goes to IDLE, the FIFO is emptied, rd_pending clears, and any in-progress read-modify-write is dropped with no write issued.
- FSM states: IDLE, MERGE.
- IDLE, req_ready:
  - Writes: req_ready = 1.
  - Reads: req_ready = (fifo_count + rd_pending < RESP_DEPTH).
- IDLE, read accepted:
  - Pins: csb=0, oeb=0, web=1, a=req_addr.
  - rd_pending is set for the next cycle.
- IDLE, full write accepted (req_wmask all ones):
  - Pins: csb=0, web=0, oeb=1, a=req_addr, i=req_wdata.
  - Single cycle; no response is generated.
- IDLE, partial write accepted (any mask bit 0, including all zeros):
  - Pins: internal read (csb=0, oeb=0, web=1).
  - addr, wdata and mask are latched; next state is MERGE.
  - This read does not set rd_pending.
- MERGE:
  - req_ready=0.
  - Pins: csb=0, web=0, oeb=1, a=latched addr.
  - i = per byte: mask ? wdata byte : sram_o byte.
  - Next state is IDLE. A partial write costs 2 cycles.
- Response path (order preserved, single FIFO):
  - In the cycle after a user read edge (rd_pending=1), the data on sram_o belongs to that read.
  - FIFO empty: resp_valid=1 and resp_rdata=sram_o (bypass, 1-cycle latency). If resp_ready=0 the word is enqueued.
  - FIFO non-empty: the sram_o word is enqueued; resp_valid=1 and resp_rdata = FIFO head.
  - Dequeue on resp_valid&&resp_ready. Simultaneous enqueue and dequeue keeps the count unchanged.
- Flow control: the credit rule above guarantees the FIFO never overflows. Back-to-back reads sustain 1/cycle when resp_ready=1.
- Ordering and hazards:
  - Read after write to the same address in the next cycle returns the new data (the macro writes at the edge).
  - A read issued in the cycle after MERGE sees the merged word.
- Reads of never-written words return whatever the macro holds; the controller does not check or mask this.

Decomposition:
- Shared package sram_ctrl_pkg: state enum (IDLE, MERGE), byte-merge function, and defaults for ADDR_WIDTH/DATA_WIDTH.
- One sub-module: sram_resp_fifo, a parameterised RESP_DEPTH x DATA_WIDTH synchronous FIFO.
  - Ports: count, full/empty, enq/deq.
  - Synchronous active-high reset.

Test Plan:
- Full write addr 0x05 data 0xDEADBEEF_01234567, then read 0x05 next cycle -> resp_valid one cycle after accept, resp_rdata=0xDEADBEEF_01234567; csb/web low for exactly 1 cycle on the write.
- Word 0x10 = 0x1111_1111_1111_1111, then partial write mask 0x0F data 0xAAAA_AAAA_AAAA_AAAA -> req_ready low 1 cycle; a later read returns 0x1111_1111_AAAA_AAAA.
- 4 back-to-back reads of addrs 1..4 with resp_ready=1 -> req_ready stays 1; responses on 4 consecutive cycles, in order.
- Same reads with resp_ready=0 -> 2 reads accepted, req_ready=0 for the 3rd; on raising resp_ready, data for addr 1 then 2 drain in order, and addrs 3, 4 follow.
- Reset asserted in the MERGE cycle of a partial write to 0x20 (previous value 0x0) -> web never low for 0x20; a read after reset returns 0x0; resp_valid=0 during reset.
- Mask 0x00 partial write to 0x30 holding 0x5555... -> word unchanged after the read-modify-write; mask 0xFF takes the single-cycle path.
